// File: rtl/atu_sequencer.sv
// ATU tune sequencer: start pulse, ack/tune supervision, retries and abort.
// All timing is in ms ticks from a prescaler that only runs outside IDLE.
`timescale 1ns/1ps
module atu_sequencer #(
  parameter int CLK_FREQ  = 73728000,
  parameter int NCH       = 2,
  parameter int START_MS  = 10,
  parameter int ACK_MS    = 500,
  parameter int TUNE_MS   = 8000,
  parameter int MAX_RETRY = 2,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tune_req,
  input  logic [CW-1:0]  tune_ch,
  input  logic           tune_abort,
  input  logic [NCH-1:0] atu_status,
  output logic [NCH-1:0] atu_start,
  output logic           busy,
  output logic           done,
  output logic [1:0]     result,
  output logic [2:0]     attempts
);

  localparam int DIV  = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TM1  = (START_MS > ACK_MS) ? START_MS : ACK_MS;
  localparam int TMAX = (TM1 > TUNE_MS) ? TM1 : TUNE_MS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] R_OK    = 2'd0;
  localparam logic [1:0] R_NOACK = 2'd1;
  localparam logic [1:0] R_TOUT  = 2'd2;
  localparam logic [1:0] R_ABORT = 2'd3;

  typedef enum logic [2:0] {
    IDLE, START, ACK, TUNE, GAP, REPORT
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  ch, ch_n;
  logic [3:0]     attempt, attempt_n;
  logic [1:0]     code, fail_code;
  logic           fail;
  logic [NCH-1:0] s1, sst;
  logic [PW-1:0]  pre;
  logic [TW-1:0]  timer;
  logic           tick, entry;
  logic           start_end, ack_end, tune_end;

  assign tick      = pre == PW'(DIV - 1);
  assign entry     = state_n != state;
  assign start_end = tick && timer == TW'(START_MS - 1);
  assign ack_end   = tick && timer == TW'(ACK_MS - 1);
  assign tune_end  = tick && timer == TW'(TUNE_MS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= '1;
      sst <= '1;
    end else begin
      s1  <= atu_status;
      sst <= s1;
    end
  end

  always_comb begin
    state_n   = state;
    ch_n      = ch;
    attempt_n = attempt;
    code      = R_OK;
    fail      = 1'b0;
    fail_code = R_NOACK;
    unique case (state)
      IDLE: begin
        if (tune_req && int'(tune_ch) < NCH) begin
          state_n   = START;
          ch_n      = tune_ch;
          attempt_n = 4'd1;
        end
      end
      START: if (start_end) state_n = ACK;
      ACK: begin
        if (!sst[ch]) begin
          state_n = TUNE;
        end else if (ack_end) begin
          fail      = 1'b1;
          fail_code = R_NOACK;
        end
      end
      TUNE: begin
        // status edge wins over a coincident timeout
        if (sst[ch]) begin
          state_n = REPORT;
          code    = R_OK;
        end else if (tune_end) begin
          fail      = 1'b1;
          fail_code = R_TOUT;
        end
      end
      GAP:    if (start_end) state_n = START;
      REPORT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (fail) begin
      if (int'(attempt) <= MAX_RETRY) begin
        state_n   = GAP;
        attempt_n = attempt + 4'd1;
      end else begin
        state_n = REPORT;
        code    = fail_code;
      end
    end
    if (tune_abort && state != IDLE && state != REPORT) begin
      state_n   = REPORT;
      attempt_n = attempt;
      code      = R_ABORT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      attempt <= '0;
      pre     <= '0;
      timer   <= '0;
    end else begin
      state   <= state_n;
      ch      <= ch_n;
      attempt <= attempt_n;
      if (entry || state_n == IDLE) begin
        pre   <= '0;
        timer <= '0;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick && timer != '1) timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      atu_start <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= R_OK;
      attempts  <= 3'd0;
    end else begin
      atu_start <= '0;
      if (state_n == START) atu_start[ch_n] <= 1'b1;
      busy <= state_n != IDLE;
      done <= state_n == REPORT;
      if (state_n == REPORT) begin
        result   <= code;
        attempts <= (attempt > 4'd7) ? 3'd7 : attempt[2:0];
      end
    end
  end

endmodule

// File: tb/tb_atu_sequencer.sv
// Bench for atu_sequencer: emulated ATU, directed scenarios, random runs.
// Expected outcomes come from a sequence-level model of the retry rules.
`timescale 1ns/1ps
module tb_atu_sequencer;

  localparam int CLK_FREQ  = 10000;
  localparam int NCH       = 2;
  localparam int START_MS  = 2;
  localparam int ACK_MS    = 5;
  localparam int TUNE_MS   = 20;
  localparam int MAX_RETRY = 1;
  localparam int MS = CLK_FREQ / 1000;
  localparam int S  = START_MS * MS;
  localparam int AK = ACK_MS * MS;
  localparam int T  = TUNE_MS * MS;
  localparam int M_OK = 0, M_NORESP = 1, M_TOUT = 2;

  logic       clk = 1'b0;
  logic       rst, tune_req, tune_abort;
  logic [0:0] tune_ch;
  logic [1:0] atu_status, atu_start;
  logic       busy, done;
  logic [1:0] result;
  logic [2:0] attempts;

  logic       oor_req, oor_abort, oor_busy, oor_done;
  logic [1:0] oor_ch, oor_result;
  logic [2:0] oor_status, oor_start, oor_attempts;

  int n_chk = 0, n_fail = 0;
  int cfg_ch = 0, cfg_mode = M_NORESP, cfg_ack = 0, cfg_tune = 0;
  int cur_len = 0, oth_hi = 0, done_cnt = 0;
  int plens[$];
  logic atu_prev;
  logic [1:0] oth_mask;
  logic d1, d2, oor_seen;
  int m, c, a, tn;

  always #5 clk = ~clk;

  atu_sequencer #(
    .CLK_FREQ(CLK_FREQ), .NCH(NCH), .START_MS(START_MS),
    .ACK_MS(ACK_MS), .TUNE_MS(TUNE_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .tune_req(tune_req), .tune_ch(tune_ch),
    .tune_abort(tune_abort), .atu_status(atu_status),
    .atu_start(atu_start), .busy(busy), .done(done),
    .result(result), .attempts(attempts)
  );

  atu_sequencer #(
    .CLK_FREQ(CLK_FREQ), .NCH(3), .START_MS(START_MS),
    .ACK_MS(ACK_MS), .TUNE_MS(TUNE_MS), .MAX_RETRY(MAX_RETRY)
  ) u_oor (
    .clk(clk), .rst(rst), .tune_req(oor_req), .tune_ch(oor_ch),
    .tune_abort(oor_abort), .atu_status(oor_status),
    .atu_start(oor_start), .busy(oor_busy), .done(oor_done),
    .result(oor_result), .attempts(oor_attempts)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs,
                           input int lo, input int hi);
    n_chk++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Sequence-level expectation: outcome, attempts, pulses, busy length.
  function automatic void ref_model(input int mode, ack, tune,
                                    output int res, att, np, lo, hi);
    int nom;
    case (mode)
      M_OK: begin
        res = 0; att = 1;
        nom = 2 + S + ack + 3 + tune;
      end
      M_NORESP: begin
        res = 1; att = MAX_RETRY + 1;
        nom = 2 + att * (S + AK) + (att - 1) * S;
      end
      default: begin
        res = 2; att = MAX_RETRY + 1;
        nom = 2 + S + ack + 3 + T + (att - 1) * (2 * S + 1 + T);
      end
    endcase
    np = att;
    lo = nom - 3;
    hi = nom + 3;
  endfunction

  // Emulated ATU: reacts to the end of a start pulse on cfg_ch.
  initial begin
    atu_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (atu_prev && !atu_start[cfg_ch] && !rst) begin
        if (cfg_mode != M_NORESP) begin
          repeat (cfg_ack) @(negedge clk);
          atu_status[cfg_ch] = 1'b0;
          if (cfg_mode == M_OK) begin
            repeat (cfg_tune) @(negedge clk);
            atu_status[cfg_ch] = 1'b1;
          end
        end
      end
      atu_prev = atu_start[cfg_ch];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (atu_start[cfg_ch]) begin
        cur_len++;
      end else if (cur_len != 0) begin
        plens.push_back(cur_len);
        cur_len = 0;
      end
      oth_mask = 2'b11;
      oth_mask[cfg_ch] = 1'b0;
      if (|(atu_start & oth_mask)) oth_hi++;
      if (done) done_cnt++;
    end
  end

  task automatic run_seq(input int ch, mode, ack, tune, input string tag);
    int res, att, np, lo, hi, n;
    ref_model(mode, ack, tune, res, att, np, lo, hi);
    atu_status = '1;
    cfg_ch = ch; cfg_mode = mode; cfg_ack = ack; cfg_tune = tune;
    repeat (4) @(negedge clk);
    plens.delete();
    cur_len = 0; oth_hi = 0; done_cnt = 0;
    tune_ch = 1'(ch);
    tune_req = 1'b1;
    @(negedge clk);
    tune_req = 1'b0;
    n = 1;
    check({tag, ".busy_up"}, busy, 1);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_rng({tag, ".busy_len"}, n, lo, hi);
    check({tag, ".result"}, result, res);
    check({tag, ".attempts"}, attempts, att);
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".pulses"}, plens.size(), np);
    check({tag, ".other_ch"}, oth_hi, 0);
    foreach (plens[i]) check($sformatf("%s.plen%0d", tag, i), plens[i], S);
  endtask

  initial begin
    rst = 1'b1; tune_req = 1'b0; tune_abort = 1'b0; tune_ch = '0;
    atu_status = '1;
    oor_req = 1'b0; oor_abort = 1'b0; oor_ch = '0; oor_status = '1;
    repeat (3) @(negedge clk);
    check("rst.atu_start", atu_start, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.result", result, 0);
    check("rst.attempts", attempts, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle.busy", busy, 0);

    run_seq(1, M_OK, 30, 40, "ok_ch1");
    run_seq(0, M_NORESP, 0, 0, "noack_ch0");
    run_seq(1, M_TOUT, 40, 0, "tout_ch1");

    atu_status = '1; cfg_ch = 1; cfg_mode = M_NORESP;
    repeat (4) @(negedge clk);
    done_cnt = 0;
    tune_ch = 1'b1; tune_req = 1'b1;
    @(negedge clk); tune_req = 1'b0;
    repeat (4) @(negedge clk);
    tune_ch = 1'b0; tune_req = 1'b1;
    @(negedge clk); tune_req = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.pre", atu_start, 2'b10);
    tune_abort = 1'b1;
    @(negedge clk); tune_abort = 1'b0;
    d1 = done;
    check("abort.start_clr", atu_start, 0);
    @(negedge clk);
    d2 = done;
    check("abort.one_done", 32'(d1) + 32'(d2), 1);
    repeat (2) @(negedge clk);
    check("abort.result", result, 3);
    check("abort.attempts", attempts, 1);
    check("abort.busy", busy, 0);
    repeat (30) @(negedge clk);
    check("abort.no_queue", busy, 0);
    check("abort.done_cnt", done_cnt, 1);

    atu_status = '1; cfg_ch = 0; cfg_mode = M_TOUT; cfg_ack = 10;
    repeat (4) @(negedge clk);
    done_cnt = 0;
    tune_ch = 1'b0; tune_req = 1'b1;
    @(negedge clk); tune_req = 1'b0;
    repeat (S + 10 + 3 + 30) @(negedge clk);
    check("rst_tune.busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_tune.busy", busy, 0);
    check("rst_tune.start", atu_start, 0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_tune.no_done", done_cnt, 0);

    atu_status = '1; cfg_ch = 1; cfg_mode = M_NORESP;
    repeat (4) @(negedge clk);
    tune_ch = 1'b1; tune_req = 1'b1;
    @(negedge clk); tune_req = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_start.pre", atu_start, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("rst_start.start", atu_start, 0);
    check("rst_start.busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_start.no_done", done_cnt, 0);
    run_seq(0, M_OK, 12, 25, "after_rst");

    oor_ch = 2'd3; oor_req = 1'b1;
    @(negedge clk); oor_req = 1'b0;
    oor_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (oor_busy || oor_done || |oor_start) oor_seen = 1'b1;
    end
    check("oor.ignored", oor_seen, 0);
    oor_ch = 2'd2; oor_req = 1'b1;
    @(negedge clk); oor_req = 1'b0;
    check("oor.last_ch_busy", oor_busy, 1);
    check("oor.last_ch_start", oor_start, 3'b100);
    oor_abort = 1'b1;
    @(negedge clk); oor_abort = 1'b0;
    @(negedge clk);
    check("oor.result", oor_result, 3);
    check("oor.attempts", oor_attempts, 1);
    check("oor.busy", oor_busy, 0);

    for (int i = 0; i < 6; i++) begin
      m  = $urandom_range(0, 2);
      c  = $urandom_range(0, 1);
      a  = $urandom_range(2, 35);
      tn = $urandom_range(5, 150);
      run_seq(c, m, a, tn, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
